// File: rtl/pipelined_cla_addsub_if.sv
// Handshake and data bundle for the pipelined carry-lookahead adder/subtractor.
// The master side supplies operands and accepts results; the slave side is the adder.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, in1, in2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/subtract built from GROUP-bit carry-lookahead groups.
// Stage k resolves sum bits [k*GROUP +: GROUP] using the carry registered by
// stage k-1. The unresolved high operand bits travel alongside in skew
// registers. The whole pipe advances together when the output slot is empty
// or is being consumed, which gives full-pipeline backpressure.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_cla_addsub_if.slave bus
);
  localparam int L = WIDTH / GROUP;

  if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_param_check
    $error("pipelined_cla_addsub: WIDTH must be a positive multiple of GROUP");
  end

  // One lookahead group. Returns {carry_out, carry_into_top_bit, sum_bits}.
  function automatic logic [GROUP+1:0] cla_group(
    input logic [GROUP-1:0] a,
    input logic [GROUP-1:0] b,
    input logic             ci
  );
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[GROUP], c[GROUP-1], p ^ c[GROUP-1:0]};
  endfunction

  // Stage registers
  logic [WIDTH-1:0] a_q [L];
  logic [WIDTH-1:0] b_q [L];
  logic [WIDTH-1:0] s_q [L];
  logic             c_q [L];
  logic             v_q [L];
  logic             msb_c_q;

  // Next-state values
  logic [WIDTH-1:0] a_d [L];
  logic [WIDTH-1:0] b_d [L];
  logic [WIDTH-1:0] s_d [L];
  logic             c_d [L];
  logic             v_d [L];
  logic             msb_c_d;

  // Inputs seen by each stage: prepared operands for stage 0, the previous
  // stage's registers otherwise.
  logic [WIDTH-1:0] a_src [L];
  logic [WIDTH-1:0] b_src [L];
  logic [WIDTH-1:0] s_src [L];
  logic             c_src [L];
  logic             v_src [L];
  logic [GROUP+1:0] grp;

  logic en;

  // The pipe may advance whenever the output slot is free or being drained.
  assign en           = !v_q[L-1] || bus.out_ready;
  assign bus.in_ready = en;

  // Route stage inputs and evaluate one lookahead group per stage.
  always_comb begin
    // NOTE: every combinationally written variable gets a default before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    msb_c_d = 1'b0;
    grp     = '0;

    // Subtraction is A + ~B + ~cin, so invert B and the incoming carry.
    a_src[0] = bus.in1;
    b_src[0] = bus.in2 ^ {WIDTH{bus.sub}};
    c_src[0] = bus.cin ^ bus.sub;
    s_src[0] = '0;
    v_src[0] = bus.in_valid;
    for (int k = 1; k < L; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      c_src[k] = c_q[k-1];
      s_src[k] = s_q[k-1];
      v_src[k] = v_q[k-1];
    end

    for (int k = 0; k < L; k++) begin
      grp    = cla_group(a_src[k][k*GROUP +: GROUP], b_src[k][k*GROUP +: GROUP], c_src[k]);
      a_d[k] = a_src[k];
      b_d[k] = b_src[k];
      s_d[k] = s_src[k];
      s_d[k][k*GROUP +: GROUP] = grp[GROUP-1:0];
      c_d[k] = grp[GROUP+1];
      v_d[k] = v_src[k];
      if (k == L-1) begin
        msb_c_d = grp[GROUP];
      end
    end
  end

  // Advance every stage together when enabled; hold everything otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are cleared along with the valid bits because
      // sum/cout/ovf come straight from the last stage and must read zero in reset.
      for (int k = 0; k < L; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      msb_c_q <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's
      // pre-edge value, which is what makes this a shift rather than a ripple.
      for (int k = 0; k < L; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      msb_c_q <= msb_c_d;
    end
  end

  assign bus.out_valid = v_q[L-1];
  assign bus.sum       = s_q[L-1];
  assign bus.cout      = c_q[L-1];
  assign bus.ovf       = msb_c_q ^ c_q[L-1];
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub (WIDTH=16, GROUP=4): directed vectors with
// literal expectations, plus an integer-arithmetic model checked every cycle.
module tb_pipelined_cla_addsub;
  localparam int WIDTH = 16;
  localparam int GROUP = 4;
  localparam int L     = WIDTH / GROUP;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_cla_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cla_addsub #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t sb[$];
  int   total     = 0;
  int   bad       = 0;
  int   cyc       = 0;
  int   n_out     = 0;
  bit   lat_check = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result from plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic s);
    exp_t e;
    int ua, ub, sa, sbv, c, r, sr;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    c   = ci ? 1 : 0;
    if (s) begin
      r      = ua - ub - c;
      sr     = sa - sbv - c;
      e.cout = (r >= 0);
    end else begin
      r      = ua + ub + c;
      sr     = sa + sbv + c;
      e.cout = (r > 65535);
    end
    e.sum  = r[15:0];
    e.ovf  = (sr > 32767) || (sr < -32768);
    e.acc  = 0;
    e.seen = 1'b0;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: scoreboard check of every valid output, push on every transfer in.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("stray_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          check("model_sum",  32'(bus.sum),  32'(sb[0].sum));
          check("model_cout", 32'(bus.cout), 32'(sb[0].cout));
          check("model_ovf",  32'(bus.ovf),  32'(sb[0].ovf));
          if (lat_check && !sb[0].seen) check("latency", 32'(cyc - sb[0].acc), 32'(L - 1));
          sb[0].seen = 1'b1;
          if (bus.out_ready) begin
            void'(sb.pop_front());
            n_out++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e     = model(bus.in1, bus.in2, bus.cin, bus.sub);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic s);
    bus.in_valid = v;
    bus.in1      = a;
    bus.in2      = b;
    bus.cin      = ci;
    bus.sub      = s;
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic s, input logic [15:0] esum,
                        input logic ecout, input logic eovf);
    bit got;
    drive(1'b1, a, b, ci, s);
    tick();
    bus.in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    check({name, "_done"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_sum"},  32'(bus.sum),  32'(esum));
      check({name, "_cout"}, 32'(bus.cout), 32'(ecout));
      check({name, "_ovf"},  32'(bus.ovf),  32'(eovf));
    end
    tick();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          stray;
    logic [15:0] pa [4];
    logic [15:0] pb [4];

    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed add/sub vectors
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_brw",  16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
    run_op("add_cin",  16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Pin the model itself against hand-computed results
    check("pin_model_sum",  32'(model(16'h1234, 16'h4321, 1'b0, 1'b1).sum),  32'h0000CF13);
    check("pin_model_cout", 32'(model(16'h1234, 16'h4321, 1'b0, 1'b1).cout), 32'd0);
    check("pin_model_ovf",  32'(model(16'h8000, 16'h8001, 1'b0, 1'b0).ovf),  32'd1);

    // Streaming: 8 back-to-back random ops
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_drain();
    check("stream_count", 32'(n_out - base), 32'd8);

    // Backpressure: fill the pipe with out_ready low, hold 5 cycles, drain
    lat_check     = 1'b0;
    base          = n_out;
    pa            = '{16'h1234, 16'h0F0F, 16'hFFFF, 16'h8000};
    pb            = '{16'h1111, 16'h00F1, 16'hFFFF, 16'h8000};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pa[i], pb[i], 1'b0, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_sum_hold",  32'(bus.sum),       32'h2345);
      check("bp_cout_hold", 32'(bus.cout),      32'd0);
      @(posedge clk);
    end
    #1;
    bus.out_ready = 1'b1;
    wait_drain();
    check("bp_count", 32'(n_out - base), 32'd4);
    lat_check = 1'b1;

    // Bubbles: in_valid 1,0,1,0 -> out_valid 1,0,1,0 after L-1 further edges
    for (int i = 0; i < 8; i++) begin
      drive((i < 4) && (i % 2 == 0), 16'(i + 1), 16'h0002, 1'b0, 1'b0);
      @(negedge clk);
      check("bubble_out_valid", 32'(bus.out_valid), 32'((i == 4) || (i == 6)));
      @(posedge clk);
      #1;
    end
    wait_drain();

    // Reset mid-flight with a result at the output and three ops behind it
    drive(1'b1, 16'h8000, 16'h8001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h3000, 16'h0001, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h00AA, 16'h0055, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_sum",       32'(bus.sum),       32'd0);
    check("midrst_cout",      32'(bus.cout),      32'd0);
    check("midrst_ovf",       32'(bus.ovf),       32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    check("no_stale_results", 32'(stray), 32'd0);
    tick();
    run_op("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
